// File: rtl/mod_cnt_pkg.sv
// Shared types, default constants and the round-robin pick helper for the
// mod-N run scheduler and its counter core.
package mod_cnt_pkg;

  localparam int MOD_DEF = 9;
  localparam int CW_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // First set request at or after ptr, wrapping within nreq requesters.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         nreq);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % nreq;
      if (!found && i < nreq && req[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mod_n_core.sv
// Synchronous mod-MOD counter with clear (priority) and count enable.
module mod_n_core
  import mod_cnt_pkg::*;
#(
  parameter int MOD = MOD_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod9_run_sched.sv
// Round-robin scheduler granting one full mod-MOD counting run per grant.
// Optional feature macro: CNT_ABORT_EN (abort a run when its requester withdraws).
module mod9_run_sched
  import mod_cnt_pkg::*;
#(
  parameter int MOD  = MOD_DEF,
  parameter int NREQ = 2,
  parameter int CW   = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic [CW-1:0]   cnt,
  output logic            done,
  output logic [2:0]      done_id,
  output logic            abort
);

  localparam logic [CW-1:0] LAST = CW'(MOD - 1);

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] winner;
  logic [2:0] pick;
  logic       clr;
  logic       en;

  assign pick = rr_pick(8'(req), ptr, NREQ);

`ifdef CNT_ABORT_EN
  // A completing run wins over a withdrawal on the same edge.
  logic withdraw;
  assign withdraw = ~|(req & gnt) && (cnt != LAST);
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    clr = 1'b1;
    en  = 1'b0;
    if (state == RUN) begin
      clr = 1'b0;
      en  = 1'b1;
`ifdef CNT_ABORT_EN
      if (withdraw) clr = 1'b1;
`endif
    end
  end

  mod_n_core #(.MOD(MOD), .CW(CW)) u_core (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .cnt (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      abort   <= 1'b0;
      ptr     <= '0;
      winner  <= '0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            winner <= pick;
            gnt    <= NREQ'(1) << pick;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            gnt     <= '0;
            done    <= 1'b1;
            done_id <= winner;
            ptr     <= 3'((int'(winner) + 1) % NREQ);
            state   <= DONE;
          end
`ifdef CNT_ABORT_EN
          else if (withdraw) begin
            gnt   <= '0;
            abort <= 1'b1;
            ptr   <= 3'((int'(winner) + 1) % NREQ);
            state <= DONE;
          end
`endif
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod9_run_sched.sv
// Directed self-checking bench for mod9_run_sched: vector table plus
// hand-written multi-cycle sequences (reset, contention, late req, abort).
module tb_mod9_run_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       busy;
  logic [4:0] cnt;
  logic       done;
  logic [2:0] done_id;
  logic       abort;

  int checks = 0;
  int errors = 0;

  mod9_run_sched #(.MOD(9), .NREQ(2), .CW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .busy    (busy),
    .cnt     (cnt),
    .done    (done),
    .done_id (done_id),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] gnt;
    logic       busy;
    logic [4:0] cnt;
    logic       done;
    logic [2:0] done_id;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done is seen; n = steps taken, or -1 if the budget expires.
  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int ndone;
  int step_no;
  int done_at[4];
  int ids[4];

  initial begin
    // Single run from a fresh reset: req=01 held, dropped after done.
    tbl[0]  = '{2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 3'd0};
    tbl[1]  = '{2'b01, 2'b01, 1'b1, 5'd0, 1'b0, 3'd0};
    tbl[2]  = '{2'b01, 2'b01, 1'b1, 5'd1, 1'b0, 3'd0};
    tbl[3]  = '{2'b01, 2'b01, 1'b1, 5'd2, 1'b0, 3'd0};
    tbl[4]  = '{2'b01, 2'b01, 1'b1, 5'd3, 1'b0, 3'd0};
    tbl[5]  = '{2'b01, 2'b01, 1'b1, 5'd4, 1'b0, 3'd0};
    tbl[6]  = '{2'b01, 2'b01, 1'b1, 5'd5, 1'b0, 3'd0};
    tbl[7]  = '{2'b01, 2'b01, 1'b1, 5'd6, 1'b0, 3'd0};
    tbl[8]  = '{2'b01, 2'b01, 1'b1, 5'd7, 1'b0, 3'd0};
    tbl[9]  = '{2'b01, 2'b01, 1'b1, 5'd8, 1'b0, 3'd0};
    tbl[10] = '{2'b01, 2'b00, 1'b1, 5'd0, 1'b1, 3'd0};
    tbl[11] = '{2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 3'd0};
    tbl[12] = '{2'b00, 2'b00, 1'b0, 5'd0, 1'b0, 3'd0};

    rst = 1'b1;
    req = 2'b00;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      step();
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("v%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
      check($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].done));
      check($sformatf("v%0d_done_id", i), 32'(done_id), 32'(tbl[i].done_id));
      check($sformatf("v%0d_abort", i), 32'(abort), 32'd0);
    end

    // Asynchronous reset in the middle of a run.
    req = 2'b01;
    step();
    repeat (4) step();
    check("mid_cnt4", 32'(cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_cnt", 32'(cnt), 32'd0);
    check("async_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_cnt", 32'(cnt), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
    end

    // Contention: req=11 held, ptr=0 after reset -> grants 0,1,0,1.
    req = 2'b11;
    step();
    check("cont_first_gnt", 32'(gnt), 32'b01);
    ndone = 0;
    step_no = 1;
    for (int i = 0; i < 60 && ndone < 4; i++) begin
      step();
      step_no++;
      if (done) begin
        done_at[ndone] = step_no;
        ids[ndone] = 32'(done_id);
        ndone++;
      end
    end
    req = 2'b00;
    check("cont_ndone", 32'(ndone), 32'd4);
    if (ndone == 4) begin
      check("cont_id0", 32'(ids[0]), 32'd0);
      check("cont_id1", 32'(ids[1]), 32'd1);
      check("cont_id2", 32'(ids[2]), 32'd0);
      check("cont_id3", 32'(ids[3]), 32'd1);
      check("cont_first_done", 32'(done_at[0]), 32'd10);
      for (int i = 1; i < 4; i++)
        check($sformatf("cont_space%0d", i), 32'(done_at[i] - done_at[i-1]), 32'd11);
    end
    step();
    step();
    check("cont_idle_busy", 32'(busy), 32'd0);

    // Late request: req[1] rises while requester 0 is at cnt=3.
    req = 2'b01;
    step();
    check("late_gnt0", 32'(gnt), 32'b01);
    repeat (3) step();
    check("late_cnt3", 32'(cnt), 32'd3);
    req = 2'b11;
    repeat (5) step();
    check("late_cnt8", 32'(cnt), 32'd8);
    check("late_still_gnt0", 32'(gnt), 32'b01);
    step();
    check("late_done", 32'(done), 32'd1);
    check("late_done_id", 32'(done_id), 32'd0);
    req = 2'b10;
    step();
    check("late_no_gnt", 32'(gnt), 32'b00);
    step();
    check("late_gnt1", 32'(gnt), 32'b10);
    check("late_gnt1_cnt", 32'(cnt), 32'd0);
    wait_done(20, n);
    check("late_run1_steps", 32'(n), 32'd9);
    check("late_run1_id", 32'(done_id), 32'd1);
    req = 2'b00;
    step();
    step();

    // Withdrawal of requester 0 at cnt=5 with requester 1 pending.
    req = 2'b11;
    step();
    check("ab_gnt0", 32'(gnt), 32'b01);
    repeat (5) step();
    check("ab_cnt5", 32'(cnt), 32'd5);
    req = 2'b10;
`ifdef CNT_ABORT_EN
    step();
    check("ab_abort", 32'(abort), 32'd1);
    check("ab_no_done", 32'(done), 32'd0);
    check("ab_cnt0", 32'(cnt), 32'd0);
    check("ab_gnt_off", 32'(gnt), 32'b00);
    step();
    check("ab_abort_pulse", 32'(abort), 32'd0);
    check("ab_gap_gnt", 32'(gnt), 32'b00);
`else
    wait_done(10, n);
    check("ab_full_run_steps", 32'(n), 32'd4);
    check("ab_full_run_id", 32'(done_id), 32'd0);
    check("ab_tied_abort", 32'(abort), 32'd0);
    step();
    check("ab_gap_gnt", 32'(gnt), 32'b00);
`endif
    step();
    check("ab_gnt1", 32'(gnt), 32'b10);
    wait_done(20, n);
    check("ab_run1_steps", 32'(n), 32'd9);
    check("ab_run1_id", 32'(done_id), 32'd1);
    req = 2'b00;
    step();
    step();

    // Withdrawal on the same edge as cnt=8: the run completes.
    req = 2'b01;
    step();
    repeat (8) step();
    check("col_cnt8", 32'(cnt), 32'd8);
    req = 2'b00;
    step();
    check("col_done", 32'(done), 32'd1);
    check("col_abort", 32'(abort), 32'd0);
    check("col_id", 32'(done_id), 32'd0);
    check("col_gnt", 32'(gnt), 32'b00);
    step();
    check("col_done_pulse", 32'(done), 32'd0);
    check("col_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
